// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and the core that talks to it.
// Holds the responder state encoding, port identifiers and default widths.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_array.sv
// Single-port word store, written on the responder's COMMIT edge.
// Read data is combinational from the latched address and is sampled by the responder on that same edge.
module mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // NOTE: storage has no reset; contents stay undefined until written, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Arbitrates instruction-fetch and data requests onto one wait-stated word store.
// Each accepted request yields exactly one single-cycle response pulse on its own port.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              busy
);

    localparam int              SC_W       = $clog2(STARVE_LIMIT + 2);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_wait_cnt, w_wait_nxt;
    logic [SC_W-1:0]   r_starve_cnt, w_starve_nxt;
    logic              r_port;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_if_rsp_valid, r_d_rsp_valid;
    logic [DATA_W-1:0] r_if_rsp_data, r_d_rsp_data;

    logic              w_idle;
    logic              w_fetch_urgent;
    logic              w_grant_d, w_grant_if, w_hs;
    logic              w_commit;
    logic [DATA_W-1:0] w_rdata;

    // Ready doubles as grant; it is held low while reset is asserted.
    assign w_idle         = (r_state == IDLE) && rst;
    assign w_fetch_urgent = if_req_valid && (r_starve_cnt == STARVE_MAX);
    assign w_grant_d      = w_idle && d_req_valid && !w_fetch_urgent;
    assign w_grant_if     = w_idle && if_req_valid && !w_grant_d;
    assign w_hs           = w_grant_d || w_grant_if;
    assign w_commit       = (r_state == COMMIT);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt  = r_state;
        w_wait_nxt   = r_wait_cnt;
        w_starve_nxt = r_starve_cnt;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    if (w_grant_d && if_req_valid) begin
                        w_starve_nxt = (r_starve_cnt == STARVE_MAX) ? r_starve_cnt
                                                                    : r_starve_cnt + 1'b1;
                    end else begin
                        w_starve_nxt = '0;
                    end
                    if (WAIT_CYCLES > 0) begin
                        w_state_nxt = WAIT;
                        w_wait_nxt  = 4'(WAIT_CYCLES - 1);
                    end else begin
                        w_state_nxt = COMMIT;
                    end
                end
            end
            WAIT: begin
                if (r_wait_cnt == 4'd0) w_state_nxt = COMMIT;
                else                    w_wait_nxt  = r_wait_cnt - 1'b1;
            end
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_wait_cnt     <= '0;
            r_starve_cnt   <= '0;
            r_port         <= PORT_IF;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_if_rsp_valid <= 1'b0;
            r_d_rsp_valid  <= 1'b0;
            r_if_rsp_data  <= '0;
            r_d_rsp_data   <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_wait_cnt     <= w_wait_nxt;
            r_starve_cnt   <= w_starve_nxt;
            r_if_rsp_valid <= 1'b0;
            r_d_rsp_valid  <= 1'b0;
            if (w_hs) begin
                r_port  <= w_grant_d ? PORT_D : PORT_IF;
                r_we    <= w_grant_d && d_req_we;
                r_addr  <= w_grant_d ? d_addr : if_addr;
                r_wdata <= d_wdata;
            end
            if (w_commit) begin
                if (r_port == PORT_D) begin
                    r_d_rsp_valid <= 1'b1;
                    r_d_rsp_data  <= r_we ? '0 : w_rdata;
                end else begin
                    r_if_rsp_valid <= 1'b1;
                    r_if_rsp_data  <= w_rdata;
                end
            end
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_commit && r_we),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign if_req_ready = w_grant_if;
    assign d_req_ready  = w_grant_d;
    assign if_rsp_valid = r_if_rsp_valid;
    assign if_rsp_data  = r_if_rsp_data;
    assign d_rsp_valid  = r_d_rsp_valid;
    assign d_rsp_data   = r_d_rsp_data;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, multi-cycle corner sequences,
// a zero-wait-state instance, and randomized traffic against a transaction-level model.
module tb_mem_responder;
    import mem_pkg::PORT_IF;
    import mem_pkg::PORT_D;

    localparam int TB_W  = 1;
    localparam int TB_SL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_valid = 1'b0, d_req_valid = 1'b0, d_req_we = 1'b0;
    logic [7:0]  if_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, busy;
    logic [31:0] if_rsp_data, d_rsp_data;

    logic        if_req_valid0 = 1'b0, d_req_valid0 = 1'b0, d_req_we0 = 1'b0;
    logic [7:0]  if_addr0 = '0, d_addr0 = '0;
    logic [31:0] d_wdata0 = '0;
    logic        if_req_ready0, d_req_ready0, if_rsp_valid0, d_rsp_valid0, busy0;
    logic [31:0] if_rsp_data0, d_rsp_data0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(TB_W), .STARVE_LIMIT(TB_SL)) u_dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .busy(busy)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0), .STARVE_LIMIT(TB_SL)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid0), .if_req_ready(if_req_ready0), .if_addr(if_addr0),
        .if_rsp_valid(if_rsp_valid0), .if_rsp_data(if_rsp_data0),
        .d_req_valid(d_req_valid0), .d_req_ready(d_req_ready0), .d_req_we(d_req_we0),
        .d_addr(d_addr0), .d_wdata(d_wdata0), .d_rsp_valid(d_rsp_valid0), .d_rsp_data(d_rsp_data0),
        .busy(busy0)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // One isolated transaction on the W-wait instance, checking acceptance, latency, pulse width and hold.
    task automatic do_txn(input logic port, input logic we, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input string nm);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        if (port == PORT_D) begin
            d_req_valid = 1'b1; d_req_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req_valid = 1'b1; if_addr = addr;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (port == PORT_D) ? d_req_ready : if_req_ready;
        end
        check_bit({nm, " accepted"}, got, 1'b1);
        @(posedge clk); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        if (!got) return;
        for (int c = 0; c <= TB_W; c++) begin
            @(negedge clk);
            check_bit({nm, " busy in flight"}, busy, 1'b1);
            check_bit({nm, " no early rsp"}, if_rsp_valid | d_rsp_valid, 1'b0);
        end
        @(negedge clk);
        check_bit({nm, " rsp pulse"}, (port == PORT_D) ? d_rsp_valid : if_rsp_valid, 1'b1);
        check_bit({nm, " other port quiet"}, (port == PORT_D) ? if_rsp_valid : d_rsp_valid, 1'b0);
        check({nm, " rsp data"}, (port == PORT_D) ? d_rsp_data : if_rsp_data, exp);
        check_bit({nm, " idle at rsp"}, busy, 1'b0);
        @(negedge clk);
        check_bit({nm, " pulse one cycle"}, (port == PORT_D) ? d_rsp_valid : if_rsp_valid, 1'b0);
        check({nm, " data held"}, (port == PORT_D) ? d_rsp_data : if_rsp_data, exp);
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[11];

    // Transaction-level model state for the randomized phase.
    logic [31:0] m_mem [16];
    bit          m_known [16];
    int          m_rem, m_streak;
    bit          m_due, m_due_port, m_due_known;
    logic [31:0] m_due_data;
    logic [31:0] held_if, held_d;
    bit          held_if_known, held_d_known;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        gs [6];
        int          ng;
        logic        got;
        logic [31:0] w0 [4];
        logic        rec_rdy [16];
        logic        rec_rv [16];
        logic [31:0] rec_rd [16];
        int          nh, h0;
        bit          e_d, e_if;
        logic [3:0]  a;

        vecs[0]  = '{PORT_D,  1'b1, 8'h05, 32'hE1A00001, 32'h00000000};
        vecs[1]  = '{PORT_IF, 1'b0, 8'h05, 32'h0,        32'hE1A00001};
        vecs[2]  = '{PORT_D,  1'b1, 8'h10, 32'hDEADBEEF, 32'h00000000};
        vecs[3]  = '{PORT_D,  1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        vecs[4]  = '{PORT_IF, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        vecs[5]  = '{PORT_D,  1'b1, 8'h07, 32'h00000001, 32'h00000000};
        vecs[6]  = '{PORT_D,  1'b0, 8'h07, 32'h0,        32'h00000001};
        vecs[7]  = '{PORT_D,  1'b1, 8'hFF, 32'hA5A5A5A5, 32'h00000000};
        vecs[8]  = '{PORT_IF, 1'b0, 8'hFF, 32'h0,        32'hA5A5A5A5};
        vecs[9]  = '{PORT_D,  1'b1, 8'h00, 32'h12345678, 32'h00000000};
        vecs[10] = '{PORT_D,  1'b0, 8'h00, 32'h0,        32'h12345678};

        // Reset state, with requests asserted so ready gating is exercised.
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_bit("reset if_req_ready", if_req_ready, 1'b0);
        check_bit("reset d_req_ready", d_req_ready, 1'b0);
        check_bit("reset rsp valids", if_rsp_valid | d_rsp_valid, 1'b0);
        check("reset if_rsp_data", if_rsp_data, 32'h0);
        check("reset d_rsp_data", d_rsp_data, 32'h0);
        check_bit("reset busy", busy, 1'b0);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_bit("idle no request ready", if_req_ready | d_req_ready, 1'b0);
        check_bit("idle not busy", busy, 1'b0);

        for (int i = 0; i < 11; i++)
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data,
                   $sformatf("vec%0d", i));

        // Both ports held valid: data wins TB_SL times in a row, then fetch.
        ng = 0;
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = 8'h10;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_addr = 8'h10;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            @(negedge clk);
            if (if_rsp_valid) check("starve if data", if_rsp_data, 32'hDEADBEEF);
            if (d_rsp_valid)  check("starve d data", d_rsp_data, 32'hDEADBEEF);
            if (if_req_ready || d_req_ready) begin
                check_bit("starve single grant", if_req_ready & d_req_ready, 1'b0);
                gs[ng] = d_req_ready ? PORT_D : PORT_IF;
                ng++;
            end
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        check("starve grant count", ng, 6);
        for (int k = 0; k < ng; k++)
            check_bit($sformatf("starve grant %0d", k), gs[k],
                      ((k % (TB_SL + 1)) == TB_SL) ? PORT_IF : PORT_D);
        repeat (TB_W + 3) @(negedge clk);

        // Reset during the WAIT phase of a store to word 7 (currently 0x1).
        got = 1'b0;
        @(posedge clk); #1;
        d_req_valid = 1'b1; d_req_we = 1'b1; d_addr = 8'h07; d_wdata = 32'h00000BAD;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = d_req_ready;
        end
        check_bit("rst-mid store accepted", got, 1'b1);
        @(posedge clk); #1;
        d_req_valid = 1'b0; d_req_we = 1'b0;
        #2 rst = 1'b0;
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        @(negedge clk);
        check_bit("mid-rst if_req_ready", if_req_ready, 1'b0);
        check_bit("mid-rst d_req_ready", d_req_ready, 1'b0);
        check_bit("mid-rst rsp valids", if_rsp_valid | d_rsp_valid, 1'b0);
        check("mid-rst if_rsp_data", if_rsp_data, 32'h0);
        check("mid-rst d_rsp_data", d_rsp_data, 32'h0);
        check_bit("mid-rst busy", busy, 1'b0);
        @(posedge clk); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0; rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_bit("post-rst no rsp", if_rsp_valid | d_rsp_valid, 1'b0);
            check_bit("post-rst idle", busy, 1'b0);
        end
        do_txn(PORT_D, 1'b0, 8'h07, 32'h0, 32'h00000001, "word7 kept");

        // Data request raised and withdrawn while a fetch is in flight.
        got = 1'b0;
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = 8'h05;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = if_req_ready;
        end
        check_bit("drop fetch accepted", got, 1'b1);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_addr = 8'h10;
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        @(negedge clk);
        check_bit("drop busy commit", busy, 1'b1);
        @(negedge clk);
        check_bit("drop fetch rsp", if_rsp_valid, 1'b1);
        check("drop fetch data", if_rsp_data, 32'hE1A00001);
        check_bit("drop idle", busy, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_bit("drop no d rsp", d_rsp_valid, 1'b0);
            check_bit("drop stays idle", busy, 1'b0);
        end

        // Zero-wait instance: preload words 0..3, then back-to-back fetches.
        w0[0] = 32'h11110000; w0[1] = 32'h22220001; w0[2] = 32'h33330002; w0[3] = 32'h44440003;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            @(posedge clk); #1;
            d_req_valid0 = 1'b1; d_req_we0 = 1'b1; d_addr0 = 8'(k); d_wdata0 = w0[k];
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = d_req_ready0;
            end
            check_bit("w0 preload accepted", got, 1'b1);
            @(posedge clk); #1;
            d_req_valid0 = 1'b0; d_req_we0 = 1'b0;
            repeat (2) @(negedge clk);
        end
        nh = 0; h0 = -1;
        @(posedge clk); #1;
        if_req_valid0 = 1'b1; if_addr0 = 8'd0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            rec_rdy[c] = if_req_ready0;
            rec_rv[c]  = if_rsp_valid0;
            rec_rd[c]  = if_rsp_data0;
            if (if_req_ready0) begin
                if (h0 < 0) h0 = c;
                nh++;
            end
            @(posedge clk); #1;
            if (nh >= 4) if_req_valid0 = 1'b0;
            else         if_addr0 = 8'(nh);
        end
        check("w0 fetch count", nh, 4);
        check_bit("w0 first fetch immediate", (h0 == 0), 1'b1);
        if (h0 >= 0 && h0 + 8 < 16) begin
            for (int k = 0; k < 4; k++) begin
                check_bit($sformatf("w0 ready slot %0d", k), rec_rdy[h0 + 2*k], 1'b1);
                check_bit($sformatf("w0 gap no ready %0d", k), rec_rdy[h0 + 2*k + 1], 1'b0);
                check_bit($sformatf("w0 gap no rsp %0d", k), rec_rv[h0 + 2*k + 1], 1'b0);
                check_bit($sformatf("w0 rsp %0d", k), rec_rv[h0 + 2*k + 2], 1'b1);
                check($sformatf("w0 rsp data %0d", k), rec_rd[h0 + 2*k + 2], w0[k]);
            end
        end

        // Randomized traffic against the transaction-level model.
        @(posedge clk); #1 rst = 1'b0;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        m_rem = 0; m_streak = 0; m_due = 0; m_due_port = PORT_IF; m_due_known = 0; m_due_data = '0;
        held_if = '0; held_d = '0; held_if_known = 1; held_d_known = 1;
        for (int i = 0; i < 16; i++) begin m_known[i] = 0; m_mem[i] = '0; end
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            e_d  = (m_rem == 0) && d_req_valid && !(if_req_valid && m_streak == TB_SL);
            e_if = (m_rem == 0) && if_req_valid && !e_d;
            check_bit("rnd if_req_ready", if_req_ready, e_if);
            check_bit("rnd d_req_ready", d_req_ready, e_d);
            check_bit("rnd busy", busy, (m_rem != 0));
            check_bit("rnd if_rsp_valid", if_rsp_valid, m_due && m_due_port == PORT_IF);
            check_bit("rnd d_rsp_valid", d_rsp_valid, m_due && m_due_port == PORT_D);
            if (m_due) begin
                if (m_due_port == PORT_IF) begin held_if = m_due_data; held_if_known = m_due_known; end
                else                       begin held_d  = m_due_data; held_d_known  = m_due_known; end
                m_due = 0;
            end
            if (held_if_known) check("rnd if_rsp_data", if_rsp_data, held_if);
            if (held_d_known)  check("rnd d_rsp_data", d_rsp_data, held_d);
            if (m_rem != 0) begin
                m_rem--;
                if (m_rem == 0) m_due = 1;
            end else if (e_d || e_if) begin
                m_due_port = e_d ? PORT_D : PORT_IF;
                if (e_d && d_req_we) begin
                    m_mem[d_addr[3:0]] = d_wdata;
                    m_known[d_addr[3:0]] = 1;
                    m_due_data = '0; m_due_known = 1;
                end else begin
                    a = e_d ? d_addr[3:0] : if_addr[3:0];
                    m_due_data = m_mem[a]; m_due_known = m_known[a];
                end
                if (e_d && if_req_valid) m_streak = (m_streak < TB_SL) ? m_streak + 1 : m_streak;
                else                     m_streak = 0;
                m_rem = TB_W + 1;
            end
            @(posedge clk); #1;
            if (e_if || (!if_req_valid && $urandom_range(0, 9) < 4)) begin
                if_req_valid = ($urandom_range(0, 1) == 1);
                if_addr = 8'($urandom_range(0, 15));
            end else if (if_req_valid && $urandom_range(0, 7) == 0) begin
                if_req_valid = 1'b0;
            end
            if (e_d || (!d_req_valid && $urandom_range(0, 9) < 5)) begin
                d_req_valid = ($urandom_range(0, 1) == 1);
                d_req_we = ($urandom_range(0, 1) == 1);
                d_addr = 8'($urandom_range(0, 15));
                d_wdata = $urandom;
            end else if (d_req_valid && $urandom_range(0, 7) == 0) begin
                d_req_valid = 1'b0;
            end
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder that services the CPU core's instruction-fetch and data load/store requests over valid/ready handshakes. It replaces direct combinational array indexing by the core with a single-port, wait-stated word store that arbitrates between the fetch port and the data port. Every accepted request returns exactly one single-cycle response pulse on the port that issued it.

## Interface
- ADDR_W, 8, word-address width; depth is 2**ADDR_W words.
- DATA_W, 32, word width.
- WAIT_CYCLES, 1, extra wait states per access, legal range 0..15.
- STARVE_LIMIT, 2, consecutive data grants allowed while a fetch is pending.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  ADDR_W  fetch word address (PC).
- if_rsp_valid  out  1  fetch response pulse.
- if_rsp_data  out  DATA_W  fetched instruction word.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted this cycle.
- d_req_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_rsp_valid  out  1  data response pulse; for a store it is an acknowledge.
- d_rsp_data  out  DATA_W  load data; 0 on a store acknowledge.
- busy  out  1  a transaction is in flight (state != IDLE).

## Operation
- States: IDLE, WAIT, COMMIT.
- In IDLE, ready is high on exactly one port, the granted one. If no request is present, neither ready is high.
- Grant rule: data wins over fetch, except that fetch wins when starve_cnt == STARVE_LIMIT.
- starve_cnt:
  - increments on each data grant while if_req_valid is high.
  - clears on a fetch grant, or on any grant with if_req_valid low.
  - saturates at STARVE_LIMIT.
- On a handshake (valid && ready at a clock edge), the block latches port, address, we and wdata.
  - It moves to WAIT with wait_cnt = WAIT_CYCLES - 1 when WAIT_CYCLES > 0.
  - Otherwise it moves to COMMIT.
- WAIT decrements wait_cnt each cycle and moves to COMMIT after the count reaches 0.
- COMMIT lasts one cycle. At its closing edge:
  - a load reads the array, or a store writes it;
  - the block registers rsp_valid = 1 and rsp_data on the latched port;
  - the state returns to IDLE.
- Responses have no backpressure. The requester must be able to accept the pulse.
- Requesters hold valid, address and data stable until ready. valid may drop without a handshake, and no effect follows.
- Array accesses are serialized. An access accepted after a store's COMMIT edge observes the stored value. This covers self-modifying code and loads from the same word.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values:
  - if_req_ready = d_req_ready = 0 while rst is low; in IDLE after reset they follow the grant rule.
  - if_rsp_valid = d_rsp_valid = 0.
  - if_rsp_data = d_rsp_data = 0.
  - busy = 0; state = IDLE; starve_cnt = 0; wait_cnt = 0.
- Latency: handshake at edge E0 gives a response high in the cycle following edge E(WAIT_CYCLES+1).
- Throughput: one transaction per WAIT_CYCLES+2 cycles. ready is high in the same cycle as the previous response pulse, because the state is already IDLE.
- Response pulses are exactly one cycle wide. rsp_data holds its value until the next response on that port.
- Simultaneous requests in IDLE: only one handshake occurs. The loser keeps valid high and is served next, subject to the grant rule.
- Reset asserted mid-transaction: the transaction is dropped. No response is issued. A store is not written unless its COMMIT edge preceded reset.
- Address range: ADDR_W bits span the full depth, so there is no out-of-range case and no wrap logic.

## Structure
- Shared package mem_pkg holds:
  - the state enum {IDLE, WAIT, COMMIT};
  - port-ID constants PORT_IF = 0, PORT_D = 1;
  - defaults for DATA_W and ADDR_W, shared with the core.
- One sub-module, mem_array: synchronous single-port word array with write enable, 2**ADDR_W × DATA_W, written and read only on the COMMIT edge.
- The grant, starve counter, wait counter and response registers stay in mem_responder.

## Test plan
- Preloaded word 5 = 0xE1A00001, WAIT_CYCLES = 1; fetch addr 5 at E0 -> if_rsp_valid high exactly after E2 with 0xE1A00001, d_rsp_valid stays 0.
- Store 0xDEADBEEF to addr 0x10, then load addr 0x10 -> store ack with d_rsp_data = 0, then load returns 0xDEADBEEF; a subsequent fetch of 0x10 also returns 0xDEADBEEF.
- Fetch and data both held valid continuously, STARVE_LIMIT = 2 -> grant order D, D, IF, D, D, IF; no handshake on the non-granted port.
- WAIT_CYCLES = 0 with back-to-back fetches of addresses 0..3 -> responses every 2 cycles with the correct words; ready coincides with each response pulse.
- rst pulled low during WAIT of a store to addr 7 (old value 0x1) -> no response issued, addr 7 still reads 0x1, and all outputs are 0 during reset.
- Requester drops d_req_valid before a handshake while the block is busy -> no transaction occurs and busy returns to 0 after the in-flight response.
